// File: rtl/in_reg_bank_pkg.sv
// ----------------------------------------------------------------------------
// in_reg_pkg
// Shared constants, types and helpers for the in_reg_bank input register bank.
//   MAX_SYNC_STAGES : deepest capture pipeline supported ahead of the filter
//   filt_state_e    : names the two per-channel filter conditions
//                     (idle = filtered value agrees with pipeline,
//                      count = a disagreement is being timed)
//   FILT_CW()       : width of the per-channel stability counter
// ----------------------------------------------------------------------------
package in_reg_pkg;

  localparam int MAX_SYNC_STAGES = 3;

  typedef enum logic {
    FILT_IDLE  = 1'b0,
    FILT_COUNT = 1'b1
  } filt_state_e;

  // Counter width for a given stability count. Kept at least one bit wide so
  // the declaration stays legal when the filter is disabled (count 0 or 1).
  function automatic int FILT_CW(input int cnt);
    if (cnt < 2) begin
      return 1;
    end
    return $clog2(cnt + 1);
  endfunction

endpackage

// File: rtl/in_reg_bank_if.sv
// ----------------------------------------------------------------------------
// in_reg_bank_if
// Fabric/pad-side bus of one in_reg_bank instance.
//   CE       capture enable (low = every register holds)
//   FIXHOLD  insert one extra pipeline stage
//   ISEL     per-channel bypass select
//   A2F      pad-side input data
//   IQZ      registered/filtered data, or bypass data
//   CHG      one-cycle pulse: some filtered bit changed
//   RISE     per-channel 0->1 pulse   (only with IN_REG_EDGE_DET_EN)
//   FALL     per-channel 1->0 pulse   (only with IN_REG_EDGE_DET_EN)
// master: the side that drives the pad data and controls (bench / pad ring)
// slave : the register bank itself
// Optional feature macro: IN_REG_EDGE_DET_EN
// ----------------------------------------------------------------------------
interface in_reg_bank_if #(
  parameter int WIDTH = 8
);
  logic             CE;
  logic             FIXHOLD;
  logic [WIDTH-1:0] ISEL;
  logic [WIDTH-1:0] A2F;
  logic [WIDTH-1:0] IQZ;
  logic             CHG;
`ifdef IN_REG_EDGE_DET_EN
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;

  modport master (
    output CE, FIXHOLD, ISEL, A2F,
    input  IQZ, CHG, RISE, FALL
  );

  modport slave (
    input  CE, FIXHOLD, ISEL, A2F,
    output IQZ, CHG, RISE, FALL
  );
`else
  modport master (
    output CE, FIXHOLD, ISEL, A2F,
    input  IQZ, CHG
  );

  modport slave (
    input  CE, FIXHOLD, ISEL, A2F,
    output IQZ, CHG
  );
`endif
endinterface

// File: rtl/in_reg_bank_filter.sv
// ----------------------------------------------------------------------------
// in_reg_filter
// One channel of the stability (glitch) filter.
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   ce      capture enable; low = counter and filtered value hold
//   p_i     pipeline output bit for this channel
//   val_o   filtered value as seen by the fabric
//   cur_o   current value of the change-tracking register
//   next_o  value the change-tracking register is about to take
// With FILT_CNT >= 2 the change-tracking register is the filtered value
// itself. With the filter off, the filtered value is the pipeline bit and the
// register simply remembers last cycle's pipeline bit, so change pulses appear
// one cycle after the new value is visible.
// ----------------------------------------------------------------------------
module in_reg_filter
  import in_reg_pkg::*;
#(
  parameter int FILT_CNT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic p_i,
  output logic val_o,
  output logic cur_o,
  output logic next_o
);

  logic f_q;
  logic f_d;

  generate
    if (FILT_CNT >= 2) begin : g_filt
      localparam int CW = FILT_CW(FILT_CNT);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // A disagreement must survive FILT_CNT-1 consecutive edges before it is
      // accepted; any agreeing cycle restarts the count. The accept threshold
      // is FILT_CNT-2, so the counter never reaches a value that could wrap.
      always_comb begin
        f_d   = f_q;
        cnt_d = cnt_q;
        if (ce) begin
          if (p_i == f_q) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(FILT_CNT - 2)) begin
            f_d   = p_i;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign val_o  = f_q;
      assign next_o = f_d;
    end else begin : g_pass
      always_comb begin
        f_d = f_q;
        if (ce) begin
          f_d = p_i;
        end
      end

      assign val_o  = p_i;
      assign next_o = p_i;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f_d;
    end
  end

  assign cur_o = f_q;

endmodule

// File: rtl/in_reg_bank.sv
// ----------------------------------------------------------------------------
// in_reg_bank
// Multi-channel IO input register bank (pad ring -> fabric). Captures WIDTH
// pad inputs through a short synchroniser pipeline, an optional extra hold
// stage and a per-channel stability filter; any channel can bypass to the
// raw pad value.
// Parameters:
//   WIDTH        number of channels
//   SYNC_STAGES  capture stages ahead of the filter (1..3)
//   FILT_CNT     stable cycles needed before the filtered value changes
//                (0 or 1 = filter off)
// Ports:
//   IQC    clock, rising edge
//   QRT_N  asynchronous active-low reset
//   bus    in_reg_bank_if slave (CE, FIXHOLD, ISEL, A2F in; IQZ, CHG,
//          optional RISE/FALL out)
// Optional feature macro: IN_REG_EDGE_DET_EN (registered RISE/FALL pulses)
// ----------------------------------------------------------------------------
module in_reg_bank
  import in_reg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 1,
  parameter int FILT_CNT    = 0
) (
  input  logic          IQC,
  input  logic          QRT_N,
  in_reg_bank_if.slave  bus
);

  // Out-of-range depths are clamped rather than rejected.
  localparam int NS = (SYNC_STAGES < 1) ? 1 :
                      (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES :
                      SYNC_STAGES;

  logic [WIDTH-1:0] s_q [NS];
  logic [WIDTH-1:0] s_d [NS];
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] h_d;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] f_val;
  logic [WIDTH-1:0] f_cur;
  logic [WIDTH-1:0] f_nxt;
  logic             chg_q;
  logic             chg_d;

  // Capture pipeline plus hold stage.
  always_comb begin
    s_d = s_q;
    h_d = h_q;
    if (bus.CE) begin
      s_d[0] = bus.A2F;
      for (int k = 1; k < NS; k++) begin
        s_d[k] = s_q[k-1];
      end
      h_d = s_q[NS-1];
    end
  end

  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      for (int k = 0; k < NS; k++) begin
        s_q[k] <= '0;
      end
      h_q <= '0;
    end else begin
      s_q <= s_d;
      h_q <= h_d;
    end
  end

  // Switching FIXHOLD mid-stream only repeats or skips one sample; both
  // sources are always-defined registers.
  assign p = bus.FIXHOLD ? h_q : s_q[NS-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      in_reg_filter #(
        .FILT_CNT (FILT_CNT)
      ) u_filt (
        .clk    (IQC),
        .rst_n  (QRT_N),
        .ce     (bus.CE),
        .p_i    (p[gi]),
        .val_o  (f_val[gi]),
        .cur_o  (f_cur[gi]),
        .next_o (f_nxt[gi])
      );
    end
  endgenerate

  // Change pulse holds with CE low so a pending pulse is neither lost nor
  // repeated across a stall.
  always_comb begin
    chg_d = chg_q;
    if (bus.CE) begin
      chg_d = |(f_nxt ^ f_cur);
    end
  end

  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign bus.CHG = chg_q;

  // Bypass is purely combinational and independent of reset.
  assign bus.IQZ = (bus.ISEL & bus.A2F) | (~bus.ISEL & f_val);

`ifdef IN_REG_EDGE_DET_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;

  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    if (bus.CE) begin
      rise_d = ~f_cur & f_nxt;
      fall_d = f_cur & ~f_nxt;
    end
  end

  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.RISE = rise_q;
  assign bus.FALL = fall_q;
`endif

endmodule

// File: tb/tb_in_reg_bank.sv
// ----------------------------------------------------------------------------
// tb_in_reg_bank
// Two banks (SYNC_STAGES=2; FILT_CNT=0 and FILT_CNT=4) share one stimulus.
// Expected IQZ/CHG per cycle are queued when stimulus is applied and popped
// as the cycles elapse. Cycle 0 = the cycle the stimulus is first applied;
// cycle N = just after the N-th following rising edge.
// Optional feature macro: IN_REG_EDGE_DET_EN
// ----------------------------------------------------------------------------
module tb_in_reg_bank;

  typedef struct {
    int         cyc;
    bit         sel;   // 0 = filter-off bank, 1 = FILT_CNT=4 bank
    logic [7:0] iqz;
    logic       chg;
  } exp_t;

  logic       iqc = 1'b0;
  logic       qrt_n = 1'b0;
  logic       ce;
  logic       fixhold;
  logic [7:0] isel;
  logic [7:0] a2f;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 iqc = ~iqc;

  in_reg_bank_if #(.WIDTH(8)) if0 ();
  in_reg_bank_if #(.WIDTH(8)) if4 ();

  assign if0.CE      = ce;
  assign if0.FIXHOLD = fixhold;
  assign if0.ISEL    = isel;
  assign if0.A2F     = a2f;
  assign if4.CE      = ce;
  assign if4.FIXHOLD = fixhold;
  assign if4.ISEL    = isel;
  assign if4.A2F     = a2f;

  in_reg_bank #(.WIDTH(8), .SYNC_STAGES(2), .FILT_CNT(0)) dut0 (
    .IQC(iqc), .QRT_N(qrt_n), .bus(if0)
  );

  in_reg_bank #(.WIDTH(8), .SYNC_STAGES(2), .FILT_CNT(4)) dut4 (
    .IQC(iqc), .QRT_N(qrt_n), .bus(if4)
  );

  task automatic settle(input int n);
    @(negedge iqc);
    ce = 1'b1; fixhold = 1'b0; isel = 8'h00; a2f = 8'h00;
    repeat (n) @(negedge iqc);
  endtask

  task automatic test_reset();
    qrt_n = 1'b0;
    #12;
    checks++; if (if0.IQZ !== 8'h00) begin failures++; $display("FAIL reset iqz0 got=%h exp=00", if0.IQZ); end
    checks++; if (if4.IQZ !== 8'h00) begin failures++; $display("FAIL reset iqz4 got=%h exp=00", if4.IQZ); end
    checks++; if (if0.CHG !== 1'b0) begin failures++; $display("FAIL reset chg0 got=%b exp=0", if0.CHG); end
    checks++; if (if4.CHG !== 1'b0) begin failures++; $display("FAIL reset chg4 got=%b exp=0", if4.CHG); end
`ifdef IN_REG_EDGE_DET_EN
    checks++; if (if0.RISE !== 8'h00 || if0.FALL !== 8'h00) begin failures++; $display("FAIL reset edge got=%h/%h exp=00/00", if0.RISE, if0.FALL); end
`endif
    @(negedge iqc);
    qrt_n = 1'b1;
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_pipeline();
    exp_t e; logic [7:0] oi; logic oc;
    settle(10);
    @(negedge iqc); a2f = 8'hA5;
    for (int c = 1; c <= 7; c++) begin
      sb.push_back('{c, 1'b0, (c >= 2) ? 8'hA5 : 8'h00, logic'(c == 3)});
      sb.push_back('{c, 1'b1, (c >= 5) ? 8'hA5 : 8'h00, logic'(c == 5)});
    end
    for (int c = 1; c <= 7; c++) begin
      @(posedge iqc); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        oi = e.sel ? if4.IQZ : if0.IQZ; oc = e.sel ? if4.CHG : if0.CHG;
        checks++; if (oi !== e.iqz) begin failures++; $display("FAIL pipeline iqz bank%0d cyc=%0d got=%h exp=%h", e.sel, c, oi, e.iqz); end
        checks++; if (oc !== e.chg) begin failures++; $display("FAIL pipeline chg bank%0d cyc=%0d got=%b exp=%b", e.sel, c, oc, e.chg); end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL pipeline leftover got=%0d exp=0", sb.size()); end
    sb.delete();
    $display("test_pipeline done checks=%0d", checks);
  endtask

  task automatic test_fixhold();
    exp_t e; logic [7:0] oi; logic oc; logic [7:0] prev;
    settle(10);
    @(negedge iqc); fixhold = 1'b1;
    repeat (3) @(negedge iqc);
    a2f = 8'hA5;
    for (int c = 1; c <= 8; c++) begin
      sb.push_back('{c, 1'b0, (c >= 3) ? 8'hA5 : 8'h00, logic'(c == 4)});
      sb.push_back('{c, 1'b1, (c >= 6) ? 8'hA5 : 8'h00, logic'(c == 6)});
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge iqc); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        oi = e.sel ? if4.IQZ : if0.IQZ; oc = e.sel ? if4.CHG : if0.CHG;
        checks++; if (oi !== e.iqz) begin failures++; $display("FAIL fixhold iqz bank%0d cyc=%0d got=%h exp=%h", e.sel, c, oi, e.iqz); end
        checks++; if (oc !== e.chg) begin failures++; $display("FAIL fixhold chg bank%0d cyc=%0d got=%b exp=%b", e.sel, c, oc, e.chg); end
      end
    end
    // Counting ramp, FIXHOLD dropped after cycle 6: one sample is skipped.
    @(negedge iqc); a2f = 8'h00;
    repeat (4) @(negedge iqc);
    a2f = 8'd1; prev = 8'h00;
    for (int c = 1; c <= 14; c++) begin
      sb.push_back('{c, 1'b0, (c <= 6) ? 8'((c > 2) ? c - 2 : 0) : 8'(c - 1), 1'b0});
    end
    for (int c = 1; c <= 14; c++) begin
      @(posedge iqc); #1;
      checks++; if ($isunknown(if0.IQZ) || if0.IQZ < prev) begin failures++; $display("FAIL fixhold monotone cyc=%0d got=%h prev=%h", c, if0.IQZ, prev); end
      prev = if0.IQZ;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++; if (if0.IQZ !== e.iqz) begin failures++; $display("FAIL fixhold ramp cyc=%0d got=%h exp=%h", c, if0.IQZ, e.iqz); end
      end
      a2f = 8'(c + 1);
      if (c == 6) fixhold = 1'b0;
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL fixhold leftover got=%0d exp=0", sb.size()); end
    sb.delete();
    $display("test_fixhold done checks=%0d", checks);
  endtask

  task automatic test_filter();
    exp_t e; logic [7:0] oi; logic oc;
    settle(10);
    // 2-cycle pulse: rejected by the FILT_CNT=4 bank.
    @(negedge iqc); a2f = 8'h01;
    for (int c = 1; c <= 8; c++) begin
      sb.push_back('{c, 1'b0, (c == 2 || c == 3) ? 8'h01 : 8'h00, logic'(c == 3 || c == 5)});
      sb.push_back('{c, 1'b1, 8'h00, 1'b0});
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge iqc); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        oi = e.sel ? if4.IQZ : if0.IQZ; oc = e.sel ? if4.CHG : if0.CHG;
        checks++; if (oi !== e.iqz) begin failures++; $display("FAIL glitch iqz bank%0d cyc=%0d got=%h exp=%h", e.sel, c, oi, e.iqz); end
        checks++; if (oc !== e.chg) begin failures++; $display("FAIL glitch chg bank%0d cyc=%0d got=%b exp=%b", e.sel, c, oc, e.chg); end
      end
      if (c == 2) a2f = 8'h00;
    end
    // 5-cycle level: accepted SYNC_STAGES+3 cycles after the edge, then released.
    @(negedge iqc); a2f = 8'h01;
    for (int c = 1; c <= 11; c++) begin
      sb.push_back('{c, 1'b0, (c >= 2 && c <= 6) ? 8'h01 : 8'h00, logic'(c == 3 || c == 8)});
      sb.push_back('{c, 1'b1, (c >= 5 && c <= 9) ? 8'h01 : 8'h00, logic'(c == 5 || c == 10)});
    end
    for (int c = 1; c <= 11; c++) begin
      @(posedge iqc); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        oi = e.sel ? if4.IQZ : if0.IQZ; oc = e.sel ? if4.CHG : if0.CHG;
        checks++; if (oi !== e.iqz) begin failures++; $display("FAIL level iqz bank%0d cyc=%0d got=%h exp=%h", e.sel, c, oi, e.iqz); end
        checks++; if (oc !== e.chg) begin failures++; $display("FAIL level chg bank%0d cyc=%0d got=%b exp=%b", e.sel, c, oc, e.chg); end
      end
      if (c == 5) a2f = 8'h00;
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL filter leftover got=%0d exp=0", sb.size()); end
    sb.delete();
    $display("test_filter done checks=%0d", checks);
  endtask

  task automatic test_bypass();
    exp_t e; logic [7:0] oi; logic oc;
    settle(10);
    @(negedge iqc); isel = 8'h0F; a2f = 8'h3C;
    for (int c = 0; c <= 6; c++) begin
      sb.push_back('{c, 1'b0, (c >= 2) ? 8'h3C : 8'h0C, logic'(c == 3)});
      sb.push_back('{c, 1'b1, (c >= 5) ? 8'h3C : 8'h0C, logic'(c == 5)});
    end
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(posedge iqc);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        oi = e.sel ? if4.IQZ : if0.IQZ; oc = e.sel ? if4.CHG : if0.CHG;
        checks++; if (oi !== e.iqz) begin failures++; $display("FAIL bypass iqz bank%0d cyc=%0d got=%h exp=%h", e.sel, c, oi, e.iqz); end
        checks++; if (oc !== e.chg) begin failures++; $display("FAIL bypass chg bank%0d cyc=%0d got=%b exp=%b", e.sel, c, oc, e.chg); end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bypass leftover got=%0d exp=0", sb.size()); end
    sb.delete();
    $display("test_bypass done checks=%0d", checks);
  endtask

  task automatic test_ce_hold();
    exp_t e;
    settle(10);
    @(negedge iqc); a2f = 8'h11;
    for (int c = 1; c <= 11; c++) begin
      sb.push_back('{c, 1'b0, (c == 1) ? 8'h00 : (c <= 8) ? 8'h11 : 8'h22,
                     logic'(c == 3 || (c >= 4 && c <= 7) || c == 10)});
    end
    for (int c = 1; c <= 11; c++) begin
      @(posedge iqc); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++; if (if0.IQZ !== e.iqz) begin failures++; $display("FAIL ce_hold iqz cyc=%0d got=%h exp=%h", c, if0.IQZ, e.iqz); end
        checks++; if (if0.CHG !== e.chg) begin failures++; $display("FAIL ce_hold chg cyc=%0d got=%b exp=%b", c, if0.CHG, e.chg); end
      end
      if (c >= 3 && c <= 6) begin ce = 1'b0; a2f = 8'(8'h40 + c); end
      if (c == 7) begin ce = 1'b1; a2f = 8'h22; end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ce_hold leftover got=%0d exp=0", sb.size()); end
    sb.delete();
    $display("test_ce_hold done checks=%0d", checks);
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [7:0] oi; logic oc;
    settle(10);
    @(negedge iqc); isel = 8'h80; a2f = 8'h81;
    for (int c = 1; c <= 4; c++) begin
      sb.push_back('{c, 1'b0, (c >= 2) ? 8'h81 : 8'h80, logic'(c == 3)});
      sb.push_back('{c, 1'b1, 8'h80, 1'b0});
    end
    for (int c = 1; c <= 4; c++) begin
      @(posedge iqc); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        oi = e.sel ? if4.IQZ : if0.IQZ; oc = e.sel ? if4.CHG : if0.CHG;
        checks++; if (oi !== e.iqz) begin failures++; $display("FAIL rst_pre iqz bank%0d cyc=%0d got=%h exp=%h", e.sel, c, oi, e.iqz); end
        checks++; if (oc !== e.chg) begin failures++; $display("FAIL rst_pre chg bank%0d cyc=%0d got=%b exp=%b", e.sel, c, oc, e.chg); end
      end
    end
    // Asynchronous assertion between edges: effect is immediate.
    #2; qrt_n = 1'b0; #1;
    checks++; if (if0.IQZ !== 8'h80) begin failures++; $display("FAIL rst_async iqz0 got=%h exp=80", if0.IQZ); end
    checks++; if (if4.IQZ !== 8'h80) begin failures++; $display("FAIL rst_async iqz4 got=%h exp=80", if4.IQZ); end
    checks++; if (if0.CHG !== 1'b0 || if4.CHG !== 1'b0) begin failures++; $display("FAIL rst_async chg got=%b/%b exp=0/0", if0.CHG, if4.CHG); end
    @(negedge iqc); qrt_n = 1'b1;
    // Count restarts from zero after release.
    for (int c = 1; c <= 7; c++) begin
      sb.push_back('{c, 1'b0, (c >= 2) ? 8'h81 : 8'h80, logic'(c == 3)});
      sb.push_back('{c, 1'b1, (c >= 5) ? 8'h81 : 8'h80, logic'(c == 5)});
    end
    for (int c = 1; c <= 7; c++) begin
      @(posedge iqc); #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        oi = e.sel ? if4.IQZ : if0.IQZ; oc = e.sel ? if4.CHG : if0.CHG;
        checks++; if (oi !== e.iqz) begin failures++; $display("FAIL rst_post iqz bank%0d cyc=%0d got=%h exp=%h", e.sel, c, oi, e.iqz); end
        checks++; if (oc !== e.chg) begin failures++; $display("FAIL rst_post chg bank%0d cyc=%0d got=%b exp=%b", e.sel, c, oc, e.chg); end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL reset_mid leftover got=%0d exp=0", sb.size()); end
    sb.delete();
    $display("test_reset_mid done checks=%0d", checks);
  endtask

`ifdef IN_REG_EDGE_DET_EN
  task automatic test_edge_det();
    logic [7:0] er; logic [7:0] ef;
    settle(10);
    @(negedge iqc); a2f = 8'h0F;
    for (int c = 1; c <= 9; c++) begin
      @(posedge iqc); #1;
      er = (c == 3) ? 8'h0F : 8'h00;
      ef = (c == 8) ? 8'h0F : 8'h00;
      checks++; if (if0.RISE !== er) begin failures++; $display("FAIL edge rise cyc=%0d got=%h exp=%h", c, if0.RISE, er); end
      checks++; if (if0.FALL !== ef) begin failures++; $display("FAIL edge fall cyc=%0d got=%h exp=%h", c, if0.FALL, ef); end
      checks++; if (if0.CHG !== logic'(c == 3 || c == 8)) begin failures++; $display("FAIL edge chg cyc=%0d got=%b", c, if0.CHG); end
      if (c == 5) a2f = 8'h00;
    end
    $display("test_edge_det done checks=%0d", checks);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ce = 1'b1; fixhold = 1'b0; isel = 8'h00; a2f = 8'h00;
    test_reset();
    test_pipeline();
    test_fixhold();
    test_filter();
    test_bypass();
    test_ce_hold();
    test_reset_mid();
`ifdef IN_REG_EDGE_DET_EN
    test_edge_det();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
